// File: rtl/spi_cmd_sched_if.sv
// Request/grant and SPI-side signals of the command scheduler.
// master: the requester / SPI state machine side. slave: the scheduler.
interface spi_cmd_sched_if #(
  parameter int CNT_W = 8
);
  logic             req_wr;
  logic             req_rd;
  logic             req_fifo;
  logic [CNT_W-1:0] fifo_words;
  logic             spi_done;
  logic             err_clr;
  logic [3:0]       cmd;
  logic [CNT_W-1:0] fifo_pk_sz;
  logic             gnt_wr;
  logic             gnt_rd;
  logic             gnt_fifo;
  logic             xfer_done;
  logic             spi_abort;
  logic             busy;
  logic             timeout_err;

  modport master (
    output req_wr, req_rd, req_fifo, fifo_words, spi_done, err_clr,
    input  cmd, fifo_pk_sz, gnt_wr, gnt_rd, gnt_fifo, xfer_done, spi_abort,
           busy, timeout_err
  );

  modport slave (
    input  req_wr, req_rd, req_fifo, fifo_words, spi_done, err_clr,
    output cmd, fifo_pk_sz, gnt_wr, gnt_rd, gnt_fifo, xfer_done, spi_abort,
           busy, timeout_err
  );
endinterface

// File: rtl/spi_cmd_sched.sv
// Round-robin command scheduler in front of the SPI slave state machine.
// Grants one of register write / register read / FIFO packet send, issues a
// single CMD pulse, then holds the grant until the expected DONE pulses arrive.
// A watchdog aborts a transfer whose DONE pulses stop coming.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no transfer; arbitrate eligible requests each cycle
// ST_ISSUE | one cycle: grant asserted, cmd and packet size presented
// ST_WAIT  | grant held; count DONE pulses, watchdog running
// ST_DONE  | one cycle: xfer_done pulse, grant still high
// ST_ABORT | one cycle: spi_abort pulse, grant already dropped
module spi_cmd_sched #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 8
) (
  input  logic            clk,
  input  logic            rst,
  spi_cmd_sched_if.slave  bus
);
  localparam int              WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  localparam logic [1:0] T_WR   = 2'd0;
  localparam logic [1:0] T_RD   = 2'd1;
  localparam logic [1:0] T_FIFO = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE,
    ST_ABORT
  } state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] remaining;
  logic [WD_W-1:0]  wdog;

  logic [3:0] elig;
  logic [1:0] cand1;
  logic [1:0] cand2;
  logic [1:0] win;
  logic       found;

  assign bus.busy = (state != ST_IDLE);

  // Round-robin pick: search from ptr in WR -> RD -> FIFO order; a FIFO
  // request with an empty packet is not eligible.
  always_comb begin
    elig  = {1'b0, bus.req_fifo && (bus.fifo_words != '0), bus.req_rd, bus.req_wr};
    cand1 = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    cand2 = (ptr == 2'd0) ? 2'd2 : ptr - 2'd1;
    found = |elig;
    win   = ptr;
    if (elig[ptr])        win = ptr;
    else if (elig[cand1]) win = cand1;
    else if (elig[cand2]) win = cand2;
  end

  // Scheduler FSM with registered grant, command and pulse outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_IDLE;
      ptr             <= T_WR;
      remaining       <= '0;
      wdog            <= '0;
      bus.cmd         <= 4'd0;
      bus.fifo_pk_sz  <= '0;
      bus.gnt_wr      <= 1'b0;
      bus.gnt_rd      <= 1'b0;
      bus.gnt_fifo    <= 1'b0;
      bus.xfer_done   <= 1'b0;
      bus.spi_abort   <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.xfer_done <= 1'b0;
      bus.spi_abort <= 1'b0;
      // Clear first so that an abort in the same cycle overrides it.
      if (bus.err_clr) bus.timeout_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (found) begin
            state        <= ST_ISSUE;
            ptr          <= (win == 2'd2) ? 2'd0 : win + 2'd1;
            bus.gnt_wr   <= (win == T_WR);
            bus.gnt_rd   <= (win == T_RD);
            bus.gnt_fifo <= (win == T_FIFO);
            if (win == T_FIFO) begin
              remaining      <= bus.fifo_words;
              bus.fifo_pk_sz <= bus.fifo_words - CNT_W'(1);
              bus.cmd        <= 4'd1;
            end else begin
              remaining      <= CNT_W'(1);
              bus.fifo_pk_sz <= '0;
              bus.cmd        <= (win == T_RD) ? 4'd2 : 4'd3;
            end
          end
        end
        ST_ISSUE: begin
          bus.cmd <= 4'd0;
          wdog    <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.spi_done) begin
            wdog      <= '0;
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state         <= ST_DONE;
              bus.xfer_done <= 1'b1;
            end
          end else if (wdog == WD_LAST) begin
            state           <= ST_ABORT;
            bus.spi_abort   <= 1'b1;
            bus.timeout_err <= 1'b1;
            bus.gnt_wr      <= 1'b0;
            bus.gnt_rd      <= 1'b0;
            bus.gnt_fifo    <= 1'b0;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        ST_DONE: begin
          bus.gnt_wr   <= 1'b0;
          bus.gnt_rd   <= 1'b0;
          bus.gnt_fifo <= 1'b0;
          state        <= ST_IDLE;
        end
        ST_ABORT: begin
          wdog  <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_cmd_sched.sv
// Scoreboard bench for spi_cmd_sched: stimulus pushes expected grants and
// transfer outcomes, a monitor pops and compares whenever the DUT presents
// cmd, xfer_done or spi_abort.
module tb_spi_cmd_sched;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  spi_cmd_sched_if #(.CNT_W(CNT_W)) bus ();

  spi_cmd_sched #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       cmd;
    bit [2:0] gnt;   // {wr, rd, fifo}
    int       pksz;
  } gexp_t;

  typedef struct {
    bit       abort;
    bit [2:0] gnt;
  } dexp_t;

  gexp_t gq[$];
  dexp_t dq[$];
  int    checks = 0;
  int    errors = 0;
  int    ptr_m  = 0;   // reference round-robin pointer: 0 WR, 1 RD, 2 FIFO

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input bit [2:0] e);
    for (int i = 0; i < 3; i++) begin
      if (e[(ptr_m + i) % 3]) return (ptr_m + i) % 3;
    end
    return -1;
  endfunction

  function automatic void push_grant(input int t, input int words);
    gexp_t g;
    g.cmd  = (t == 0) ? 3 : (t == 1) ? 2 : 1;
    g.gnt  = (t == 0) ? 3'b100 : (t == 1) ? 3'b010 : 3'b001;
    g.pksz = (t == 2) ? words - 1 : 0;
    gq.push_back(g);
    ptr_m = (t + 1) % 3;
  endfunction

  function automatic bit [2:0] gvec();
    return {bus.gnt_wr, bus.gnt_rd, bus.gnt_fifo};
  endfunction

  // Monitor: compare DUT outputs against queued expectations.
  gexp_t mg;
  dexp_t md;
  always @(negedge clk) begin
    if (rst) begin
      if (bus.cmd != 4'd0) begin
        if (gq.size() == 0) check("unexpected_grant", int'(bus.cmd), 0);
        else begin
          mg = gq.pop_front();
          check("cmd", int'(bus.cmd), mg.cmd);
          check("gnt_issue", int'(gvec()), int'(mg.gnt));
          check("pk_sz", int'(bus.fifo_pk_sz), mg.pksz);
          check("busy_issue", int'(bus.busy), 1);
        end
      end
      if (bus.xfer_done) begin
        if (dq.size() == 0) check("unexpected_xfer_done", 1, 0);
        else begin
          md = dq.pop_front();
          check("done_kind", 0, int'(md.abort));
          check("gnt_at_done", int'(gvec()), int'(md.gnt));
        end
      end
      if (bus.spi_abort) begin
        if (dq.size() == 0) check("unexpected_abort", 1, 0);
        else begin
          md = dq.pop_front();
          check("abort_kind", 1, int'(md.abort));
          check("gnt_at_abort", int'(gvec()), 0);
          check("timeout_err_set", int'(bus.timeout_err), 1);
        end
      end
    end
  end

  task automatic clear_reqs();
    bus.req_wr   = 1'b0;
    bus.req_rd   = 1'b0;
    bus.req_fifo = 1'b0;
  endtask

  task automatic wait_idle();
    int c = 0;
    while (bus.busy && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (bus.busy) check("idle_timeout", int'(bus.busy), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd"}, int'(bus.cmd), 0);
    check({tag, "_pk_sz"}, int'(bus.fifo_pk_sz), 0);
    check({tag, "_gnt"}, int'(gvec()), 0);
    check({tag, "_pulses"}, int'({bus.xfer_done, bus.spi_abort}), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_timeout_err"}, int'(bus.timeout_err), 0);
  endtask

  // mode: 0 random outcome, 1 force completion, 2 force watchdog abort
  task automatic run_xfer(input bit wr, input bit rd, input bit ff,
                          input int words, input int mode);
    bit [2:0] e;
    int t, n, k, g;
    bit ab, hold, seen;
    dexp_t d;
    wait_idle();
    bus.req_wr     = wr;
    bus.req_rd     = rd;
    bus.req_fifo   = ff;
    bus.fifo_words = CNT_W'(words);
    e = {ff && (words != 0), rd, wr};
    t = pick(e);
    if (t < 0) begin
      @(negedge clk);
      check("no_grant_busy", int'(bus.busy), 0);
      clear_reqs();
      return;
    end
    push_grant(t, words);
    n  = (t == 2) ? words : 1;
    ab = (mode == 2) || (mode == 0 && ($urandom % 5) == 0);
    k  = ab ? $urandom_range(n - 1, 0) : n;
    d.abort = ab;
    d.gnt   = (t == 0) ? 3'b100 : (t == 1) ? 3'b010 : 3'b001;
    dq.push_back(d);
    hold = ab && ($urandom % 2 == 1);

    @(negedge clk);  // ISSUE: late request / size changes and DONE are ignored
    bus.req_wr     = 1'($urandom);
    bus.req_rd     = 1'($urandom);
    bus.req_fifo   = 1'($urandom);
    bus.fifo_words = CNT_W'($urandom_range(7, 0));
    bus.spi_done   = 1'($urandom);
    @(negedge clk);
    bus.spi_done = 1'b0;
    if (hold) bus.err_clr = 1'b1;

    for (int j = 0; j < k; j++) begin
      g = $urandom_range(3, 0);
      repeat (g) @(negedge clk);
      bus.spi_done = 1'b1;
      @(negedge clk);
      bus.spi_done = 1'b0;
      check("xfer_done_after_done", int'(bus.xfer_done), (j == n - 1) ? 1 : 0);
    end

    if (!ab) begin
      clear_reqs();
    end else begin
      seen = 1'b0;
      repeat (TIMEOUT - 1) begin
        @(negedge clk);
        if (bus.spi_abort) seen = 1'b1;
      end
      check("abort_early", int'(seen), 0);
      @(negedge clk);
      check("abort_timing", int'(bus.spi_abort), 1);
      clear_reqs();
      bus.err_clr = 1'b1;
      @(negedge clk);
      bus.err_clr = 1'b0;
      check("err_clr", int'(bus.timeout_err), 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    clear_reqs();
    bus.fifo_words = '0;
    bus.spi_done   = 1'b0;
    bus.err_clr    = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // all three held, two-word packets: WR, RD, FIFO, WR
    for (int i = 0; i < 4; i++) run_xfer(1'b1, 1'b1, 1'b1, 2, 1);
    // single write, then a four-word FIFO packet
    run_xfer(1'b1, 1'b0, 1'b0, 0, 1);
    run_xfer(1'b0, 1'b0, 1'b1, 4, 1);
    // read with no DONE: watchdog abort, then err_clr
    run_xfer(1'b0, 1'b1, 1'b0, 0, 2);
    // empty FIFO packet is never granted; with a read pending the read wins
    run_xfer(1'b0, 1'b0, 1'b1, 0, 1);
    run_xfer(1'b0, 1'b1, 1'b1, 0, 1);

    for (int i = 0; i < 150; i++)
      run_xfer(1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(6, 0), 0);

    // reset during the WAIT of a five-word FIFO packet
    wait_idle();
    bus.req_fifo   = 1'b1;
    bus.fifo_words = CNT_W'(5);
    push_grant(2, 5);
    @(negedge clk);
    @(negedge clk);
    bus.req_fifo = 1'b0;
    repeat (2) begin
      bus.spi_done = 1'b1;
      @(negedge clk);
      bus.spi_done = 1'b0;
      @(negedge clk);
    end
    check("busy_before_reset", int'(bus.busy), 1);
    #3 rst = 1'b0;
    #1 check_all_zero("mid_reset");
    @(negedge clk);
    rst   = 1'b1;
    ptr_m = 0;
    @(negedge clk);
    check_all_zero("after_reset");
    run_xfer(1'b1, 1'b1, 1'b1, 3, 1);
    run_xfer(1'b1, 1'b1, 1'b1, 3, 1);

    wait_idle();
    repeat (3) @(negedge clk);
    check("grant_queue_empty", gq.size(), 0);
    check("done_queue_empty", dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
